// File: rtl/mode_countdown.sv
// Mode-selected seconds countdown: loads DUR_n on a start edge and counts down once per CLK_PER_SEC cycles.
// Latency: load visible the cycle after the start edge; expiry lands duration*CLK_PER_SEC cycles after load.
module mode_countdown #(
  parameter int CLK_PER_SEC = 100000000,
  parameter int DUR_1       = 10,
  parameter int DUR_2       = 30,
  parameter int DUR_3       = 59
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       countdown_start_i,
  input  logic [1:0] mode_i,
  output logic [5:0] remaining_o,
  output logic [2:0] tens_o,
  output logic [3:0] ones_o,
  output logic       running_o,
  output logic       done_o,
  output logic       alarm_o,
  output logic [1:0] mode_o
);

  localparam int PW = $clog2(CLK_PER_SEC);
  localparam logic [PW-1:0] TICK_LAST = PW'(CLK_PER_SEC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] prescaler;
  logic          start_q;
  logic          start_edge;
  logic          sec_tick;

  function automatic logic [5:0] duration(input logic [1:0] m);
    case (m)
      2'b01:   return 6'(DUR_1);
      2'b10:   return 6'(DUR_2);
      2'b11:   return 6'(DUR_3);
      default: return 6'd0;
    endcase
  endfunction

  assign start_edge = countdown_start_i & ~start_q;
  assign sec_tick   = (state == RUN) && (prescaler == TICK_LAST);
  assign running_o  = (state == RUN);
  assign alarm_o    = (state == DONE);

  // Digit split only needs to be valid for 0..59.
  assign tens_o = 3'(remaining_o / 6'd10);
  assign ones_o = 4'(remaining_o % 6'd10);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      remaining_o <= 6'd0;
      mode_o      <= 2'b00;
      prescaler   <= '0;
      done_o      <= 1'b0;
      // Reset high so a start level held through reset release is not seen as an edge.
      start_q     <= 1'b1;
    end else begin
      start_q <= countdown_start_i;
      done_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_edge && (mode_i != 2'b00)) begin
            state       <= RUN;
            remaining_o <= duration(mode_i);
            mode_o      <= mode_i;
            prescaler   <= '0;
          end
        end
        RUN: begin
          // Dropping the start level aborts, even on the tick cycle.
          if (!countdown_start_i) begin
            state       <= IDLE;
            remaining_o <= 6'd0;
            mode_o      <= 2'b00;
            prescaler   <= '0;
          end else if (sec_tick) begin
            prescaler <= '0;
            if (remaining_o > 6'd1) begin
              remaining_o <= remaining_o - 6'd1;
            end else begin
              remaining_o <= 6'd0;
              state       <= DONE;
              done_o      <= 1'b1;
            end
          end else begin
            prescaler <= prescaler + PW'(1);
          end
        end
        DONE: begin
          if (!countdown_start_i) begin
            state       <= IDLE;
            remaining_o <= 6'd0;
            mode_o      <= 2'b00;
            prescaler   <= '0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mode_countdown.md
MODE_COUNTDOWN -- requirements
Module: mode_countdown

Interface
REQ-001 Parameter CLK_PER_SEC, default 100000000, clk_i cycles per countdown second (legal 2..2^27).
REQ-002 Parameter DUR_1, default 10, seconds loaded for mode 01 (legal 1..59).
REQ-003 Parameter DUR_2, default 30, seconds loaded for mode 10 (legal 1..59).
REQ-004 Parameter DUR_3, default 59, seconds loaded for mode 11 (legal 1..59).
REQ-005 clk_i  input  1  sole clock; all logic rising-edge.
REQ-006 rst_n_i  input  1  reset; synchronous, active-low.
REQ-007 countdown_start_i  input  1  level from mode-select stage; 1 = a timed mode is selected, 0 = clear/reset mode.
REQ-008 mode_i  input  2  mode code from mode-select stage; 00 none, 01/10/11 map to DUR_1/DUR_2/DUR_3.
REQ-009 remaining_o  output  6  seconds remaining, binary.
REQ-010 tens_o  output  3  tens digit of remaining_o.
REQ-011 ones_o  output  4  ones digit of remaining_o, BCD 0..9.
REQ-012 running_o  output  1  high while in RUN.
REQ-013 done_o  output  1  one-cycle pulse on expiry.
REQ-014 alarm_o  output  1  high while in DONE.
REQ-015 mode_o  output  2  mode captured at start.

Function
REQ-016 FSM states IDLE, RUN, DONE; running_o = (state==RUN), alarm_o = (state==DONE).
REQ-017 start_q register samples countdown_start_i every cycle; start edge = countdown_start_i & ~start_q.
REQ-018 IDLE -> RUN on start edge with mode_i != 00; same cycle: remaining_o <= duration(mode_i), mode_o <= mode_i, prescaler <= 0.
REQ-019 Start edge with mode_i == 00: no transition, no output change.
REQ-020 Prescaler counts 0..CLK_PER_SEC-1 only in RUN; wraps to 0; sec tick asserted in the RUN cycle where prescaler == CLK_PER_SEC-1.
REQ-021 RUN, sec tick, remaining_o > 1: remaining_o decrements by 1.
REQ-022 RUN, sec tick, remaining_o == 1: remaining_o <= 0, state <= DONE, done_o <= 1 for exactly that one following cycle.
REQ-023 First decrement occurs CLK_PER_SEC cycles after the load edge; expiry occurs duration*CLK_PER_SEC cycles after load.
REQ-024 DONE: remaining_o holds 0, alarm_o held high; exit to IDLE only when countdown_start_i == 0.
REQ-025 countdown_start_i == 0 in RUN or DONE (abort): next cycle state IDLE, remaining_o 0, mode_o 00, prescaler 0, done_o 0; abort takes priority over sec tick.
REQ-026 mode_i changes while in RUN or DONE are ignored; mode_o and duration are fixed until return to IDLE.
REQ-027 A new start edge requires countdown_start_i to go low (forcing IDLE) then high; no restart from RUN/DONE.
REQ-028 tens_o/ones_o are combinational functions of remaining_o: tens = remaining_o/10, ones = remaining_o%10; valid for 0..59.
REQ-029 IDLE: remaining_o held at last value (0 after reset, abort or expiry).

Reset
REQ-030 rst_n_i low at a clock edge: state IDLE, remaining_o 0, mode_o 00, prescaler 0, done_o 0, start_q 1.
REQ-031 start_q resetting to 1 means countdown_start_i held high through reset release produces no start.
REQ-032 Reset asserted mid-RUN or in DONE overrides all other events that cycle.

Verification (CLK_PER_SEC=4, defaults otherwise)
REQ-033 start 0->1 with mode 01 -> running_o 1, remaining_o 10, mode_o 01; remaining_o 9 after 4 cycles; done_o single pulse at cycle 40, alarm_o 1, tens_o 0, ones_o 0.
REQ-034 mode 11 start -> remaining_o 59, tens_o 5, ones_o 9; after 4 cycles 58, tens_o 5, ones_o 8.
REQ-035 mode 10 start, switch mode_i to 01 after 6 cycles -> mode_o stays 10, remaining_o 29 then 28 on schedule.
REQ-036 start drops to 0 in RUN coincident with sec tick -> IDLE, remaining_o 0, no done_o.
REQ-037 start held high across rst_n_i release with mode 01 -> stays IDLE; after start 0 then 1 -> RUN with remaining_o 10.
REQ-038 DONE, start stays 1 for 20 cycles -> alarm_o stays 1, done_o stays 0; start to 0 -> IDLE, alarm_o 0.
